// File: rtl/regfile_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_ADD   = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr.sv
// Two-way request arbiter. With REGFILE_ARB_RR_EN defined it alternates on
// ties using a last-grant pointer; otherwise A has fixed priority and no
// pointer state exists (the clock/reset ports are then not present).
import regfile_arb_pkg::*;

module rr_arbiter2 (
`ifdef REGFILE_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic req_a,
    input  logic req_b,
    input  logic grant_en,
    output logic grant_id,
    output logic valid
);

`ifdef REGFILE_ARB_RR_EN
    logic lastGrant;

    // Winner selection: on a tie the requester not granted last wins
    always_comb begin
        valid = grant_en & (req_a | req_b);
        if (req_a && req_b)
            grant_id = ~lastGrant;
        else if (req_b)
            grant_id = REQ_B;
        else
            grant_id = REQ_A;
    end

    // Pointer starts at B so that A wins the first tie after reset
    always_ff @(posedge clk) begin
        if (!rst)
            lastGrant <= REQ_B;
        else if (valid)
            lastGrant <= grant_id;
    end
`else
    // Fixed priority: B only wins when A is not requesting
    always_comb begin
        valid    = grant_en & (req_a | req_b);
        grant_id = (!req_a && req_b) ? REQ_B : REQ_A;
    end
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file's write port and one read port between
// requesters A and B. Plain writes take IDLE->WRITE, adds take
// IDLE->READ->WRITE. Optional macro: REGFILE_ARB_RR_EN (round-robin ties).
import regfile_arb_pkg::*;

module regfile_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              op_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic              op_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              grant_id
);

    state_t            state;
    logic [DATA_W-1:0] addend;
    logic              arbGrant;
    logic              arbValid;
    logic              winOp;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;

    // Read-modify-write sum wraps modulo 2^DATA_W; the carry is discarded
    function automatic logic [DATA_W-1:0] wrapAdd(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    rr_arbiter2 arb (
`ifdef REGFILE_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .req_a    (req_a),
        .req_b    (req_b),
        .grant_en (state == ST_IDLE),
        .grant_id (arbGrant),
        .valid    (arbValid)
    );

    // Route the winning requester's operands toward the operand registers
    always_comb begin
        winOp   = (arbGrant == REQ_B) ? op_b   : op_a;
        winAddr = (arbGrant == REQ_B) ? addr_b : addr_a;
        winData = (arbGrant == REQ_B) ? data_b : data_a;
    end

    // Control FSM; rf_wen/ack are set on entry to WRITE so they are high
    // exactly while the state is WRITE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rf_wen   <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= REQ_A;
            rf_waddr <= '0;
            rf_raddr <= '0;
            rf_wdata <= '0;
            addend   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arbValid) begin
                        grant_id <= arbGrant;
                        busy     <= 1'b1;
                        rf_waddr <= winAddr;
                        rf_raddr <= winAddr;
                        addend   <= winData;
                        if (winOp == OP_ADD) begin
                            state <= ST_READ;
                        end else begin
                            state    <= ST_WRITE;
                            rf_wdata <= winData;
                            rf_wen   <= 1'b1;
                            ack_a    <= (arbGrant == REQ_A);
                            ack_b    <= (arbGrant == REQ_B);
                        end
                    end
                end
                ST_READ: begin
                    rf_wdata <= wrapAdd(rf_rdata, addend);
                    state    <= ST_WRITE;
                    rf_wen   <= 1'b1;
                    ack_a    <= (grant_id == REQ_A);
                    ack_b    <= (grant_id == REQ_B);
                end
                ST_WRITE: begin
                    state  <= ST_IDLE;
                    rf_wen <= 1'b0;
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    rf_wen <= 1'b0;
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x8 register file.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0, op_a = 1'b0;
    logic [3:0] addr_a = '0;
    logic [7:0] data_a = '0;
    logic       ack_a;
    logic       req_b = 1'b0, op_b = 1'b0;
    logic [3:0] addr_b = '0;
    logic [7:0] data_b = '0;
    logic       ack_b;
    logic [3:0] rf_waddr, rf_raddr;
    logic [7:0] rf_wdata, rf_rdata;
    logic       rf_wen, busy, grant_id;

    int checks = 0;
    int errors = 0;

    logic       memInit = 1'b1;
    logic [7:0] rfMem [16];

    always #5 clk = ~clk;

    // Register file model: entry i = i at start, commits on posedge when enabled
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 16; i++) rfMem[i] <= 8'(i);
        end else if (rf_wen) begin
            rfMem[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata = rfMem[rf_raddr];

    regfile_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        memInit = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
        checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {ack_a, ack_b}); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant_id); end
        checks++; if ({rf_waddr, rf_raddr, rf_wdata} !== 16'h0000) begin errors++;
            $display("FAIL reset_regs: got %h want 0000", {rf_waddr, rf_raddr, rf_wdata}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        req_a = 1'b1; op_a = 1'b0; addr_a = 4'd3; data_a = 8'hA5;
        @(negedge clk);
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL wr_wen: got %b want 1", rf_wen); end
        checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL wr_waddr: got %0d want 3", rf_waddr); end
        checks++; if (rf_wdata !== 8'hA5) begin errors++; $display("FAIL wr_wdata: got %h want a5", rf_wdata); end
        checks++; if ({ack_a, ack_b} !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b want 10", {ack_a, ack_b}); end
        checks++; if ({busy, grant_id} !== 2'b10) begin errors++; $display("FAIL wr_busy_grant: got %b want 10", {busy, grant_id}); end
        req_a = 1'b0;
        @(negedge clk);
        checks++; if ({rf_wen, ack_a, busy} !== 3'b000) begin errors++; $display("FAIL wr_idle: got %b want 000", {rf_wen, ack_a, busy}); end
        checks++; if (rfMem[3] !== 8'hA5) begin errors++; $display("FAIL wr_mem3: got %h want a5", rfMem[3]); end
        checks++; if (rf_waddr !== 4'd3) begin errors++; $display("FAIL wr_hold_waddr: got %0d want 3", rf_waddr); end
    endtask

    task automatic test_add(input logic useB, input logic [3:0] addr, input logic [7:0] data,
                            input logic [7:0] expSum);
        if (useB) begin req_b = 1'b1; op_b = 1'b1; addr_b = addr; data_b = data; end
        else begin req_a = 1'b1; op_a = 1'b1; addr_a = addr; data_a = data; end
        @(negedge clk);
        checks++; if (rf_raddr !== addr) begin errors++; $display("FAIL add_raddr: got %0d want %0d", rf_raddr, addr); end
        checks++; if ({rf_wen, ack_a, ack_b, busy} !== 4'b0001) begin errors++;
            $display("FAIL add_read_ctl: got %b want 0001", {rf_wen, ack_a, ack_b, busy}); end
        @(negedge clk);
        checks++; if (rf_wdata !== expSum) begin errors++; $display("FAIL add_wdata: got %h want %h", rf_wdata, expSum); end
        checks++; if ({rf_wen, ack_a, ack_b} !== {1'b1, ~useB, useB}) begin errors++;
            $display("FAIL add_write_ctl: got %b want %b", {rf_wen, ack_a, ack_b}, {1'b1, ~useB, useB}); end
        checks++; if (grant_id !== useB) begin errors++; $display("FAIL add_grant: got %b want %b", grant_id, useB); end
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        checks++; if (rfMem[addr] !== expSum) begin errors++; $display("FAIL add_mem: got %h want %h", rfMem[addr], expSum); end
    endtask

    task automatic test_reset_mid_add();
        req_a = 1'b1; op_a = 1'b1; addr_a = 4'd1; data_a = 8'h02;
        @(negedge clk);
        checks++; if ({rf_wen, ack_a, busy} !== 3'b001) begin errors++; $display("FAIL rst_mid_read: got %b want 001", {rf_wen, ack_a, busy}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({rf_wen, ack_a, busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_abort: got %b want 000", {rf_wen, ack_a, busy}); end
        checks++; if (rfMem[1] !== 8'h01) begin errors++; $display("FAIL rst_mid_mem: got %h want 01", rfMem[1]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({rf_wen, ack_a, busy} !== 3'b001) begin errors++; $display("FAIL rst_mid_reread: got %b want 001", {rf_wen, ack_a, busy}); end
        @(negedge clk);
        checks++; if ({rf_wen, ack_a, rf_wdata} !== {2'b11, 8'h03}) begin errors++;
            $display("FAIL rst_mid_reserve: got %b/%h want 11/03", {rf_wen, ack_a}, rf_wdata); end
        req_a = 1'b0;
        @(negedge clk);
        checks++; if (rfMem[1] !== 8'h03) begin errors++; $display("FAIL rst_mid_mem2: got %h want 03", rfMem[1]); end
    endtask

    task automatic test_contention();
        int  n = 0;
        logic exp;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_a = 1'b1; op_a = 1'b0; addr_a = 4'd6; data_a = 8'h11;
        req_b = 1'b1; op_b = 1'b0; addr_b = 4'd7; data_b = 8'h22;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            @(negedge clk);
            if (ack_a || ack_b) begin
`ifdef REGFILE_ARB_RR_EN
                exp = n[0];
`else
                exp = 1'b0;
`endif
                checks++; if (grant_id !== exp) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", n, grant_id, exp); end
                checks++; if ({ack_a, ack_b} !== {~exp, exp}) begin errors++;
                    $display("FAIL cont_ack%0d: got %b want %b", n, {ack_a, ack_b}, {~exp, exp}); end
                checks++; if (rf_wdata !== (exp ? 8'h22 : 8'h11)) begin errors++;
                    $display("FAIL cont_wdata%0d: got %h want %h", n, rf_wdata, (exp ? 8'h22 : 8'h11)); end
                n++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL cont_count: got %0d acks want 4", n); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        req_a = 1'b1; op_a = 1'b1; addr_a = 4'd2; data_a = 8'h01;
        req_b = 1'b1; op_b = 1'b1; addr_b = 4'd2; data_b = 8'h01;
        seen = 1'b0;
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            @(negedge clk);
            if (ack_a || ack_b) seen = 1'b1;
        end
        checks++; if ({seen, ack_a, ack_b, rf_wdata} !== {3'b110, 8'h03}) begin errors++;
            $display("FAIL b2b_first: got seen=%b ack=%b%b wdata=%h want 1/10/03", seen, ack_a, ack_b, rf_wdata); end
        req_a = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 8 && !seen; cyc++) begin
            @(negedge clk);
            if (ack_a || ack_b) seen = 1'b1;
        end
        checks++; if ({seen, ack_a, ack_b, rf_wdata} !== {3'b101, 8'h04}) begin errors++;
            $display("FAIL b2b_second: got seen=%b ack=%b%b wdata=%h want 1/01/04", seen, ack_a, ack_b, rf_wdata); end
        req_b = 1'b0;
        @(negedge clk);
        checks++; if (rfMem[2] !== 8'h04) begin errors++; $display("FAIL b2b_mem: got %h want 04", rfMem[2]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_add(1'b1, 4'd5, 8'h10, 8'h15);
        test_add(1'b0, 4'd15, 8'hF5, 8'h04);
        test_reset_mid_add();
        test_contention();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single write port (and one read port) of the 16×8 register file between two requesters, A and B. Each requester issues either a plain write or an add (read-modify-write) via a req/ack handshake. The arbiter picks one request at a time, runs the required read and write cycles, and pulses ack on completion. It sits between the requester logic and the register file's write/read address, data and enable pins.

## Interface
- ADDR_W, 4, register address width (16 entries)
- DATA_W, 8, register data width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- req_a  in  1  request from A; held high until ack_a
- op_a  in  1  A operation: 0 = write, 1 = add
- addr_a  in  ADDR_W  A target register
- data_a  in  DATA_W  A write data / addend
- ack_a  out  1  one-cycle completion pulse to A
- req_b, op_b, addr_b, data_b, ack_b: same as the A ports, for requester B
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- rf_wen  out  1  register file write enable
- rf_raddr  out  ADDR_W  register file read address
- rf_rdata  in  DATA_W  register file read data (combinational read of rf_raddr)
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  1  owner of the current operation: 0 = A, 1 = B

## Operation
- **FSM states:** IDLE, READ, WRITE.
- **IDLE**
  - If no req is high, stay in IDLE.
  - Otherwise the arbiter picks a winner and latches its op, addr and data, and sets grant_id.
  - Next state is WRITE if op = write, READ if op = add.
- **READ**
  - rf_raddr drives the latched addr.
  - The write data register captures rf_rdata + data, truncated to DATA_W (mod 256, carry discarded).
  - Next state is WRITE.
- **WRITE**
  - rf_wen = 1, with rf_waddr/rf_wdata driven from the latched registers.
  - The winner's ack pulses this same cycle.
  - Next state is IDLE.
- **Arbitration**
  - Requests are sampled only in IDLE.
  - Operands are committed at grant. If req drops early, the operation still completes and ack still pulses.
- **Back-to-back requests:** a req still high in the cycle after ack counts as a new request.
- **Idle outputs:** rf_wen = 0, ack_a = ack_b = 0. rf_raddr/rf_waddr/rf_wdata hold their last latched values.
- **Reset mid-operation**
  - Reset in READ or WRITE aborts the operation: no rf_wen, no ack, FSM to IDLE.
  - A requester still holding req is served again after reset releases.
- **Reset values:** state IDLE; rf_wen, ack_a, ack_b, busy, grant_id = 0; rf_waddr, rf_raddr, rf_wdata = 0; round-robin pointer set so A wins the first tie.

## Timing
- Write latency: grant cycle (IDLE) + WRITE. ack arrives 1 cycle after the first cycle req is seen in IDLE; 2 cycles per op.
- Add latency: IDLE + READ + WRITE. ack arrives 2 cycles after grant; 3 cycles per op.
- The register file commits on the posedge ending WRITE. The next op's READ is at least 2 cycles later, so a read-after-write to the same register always sees the new value; no bypass is needed.
- rf_wen and ack are decoded from state, so they are glitch-free with respect to the requester inputs.

## Configuration
- Macro: REGFILE_ARB_RR_EN.
- **Defined:** 2-way round-robin. On a tie, the requester not granted last wins. The pointer updates on every grant.
- **Undefined:** fixed priority; A always wins a tie and B can starve. No pointer register is built.

## Structure
- Package regfile_arb_pkg holds:
  - state encodings ST_IDLE = 0, ST_READ = 1, ST_WRITE = 2
  - OP_WRITE = 0, OP_ADD = 1
  - REQ_A = 0, REQ_B = 1
- Sub-module rr_arbiter2:
  - inputs req_a, req_b, grant_en; output grant_id and valid
  - contains the round-robin pointer (or none, per macro)
- The top level holds the FSM and the operand/write-data registers.

## Test plan
1. **Plain write:** register file at its reset contents (entry i = i); A writes addr 3, data 8'hA5 → next cycle rf_wen = 1, rf_waddr = 3, rf_wdata = 8'hA5, ack_a pulses for 1 cycle; entry 3 reads 8'hA5.
2. **Add:** B adds addr 5, data 8'h10 → READ cycle rf_raddr = 5; WRITE cycle rf_wdata = 8'h15, ack_b pulses, grant_id = 1.
3. **Add with wrap:** A adds addr 15, data 8'hF5 → rf_wdata = 8'h04 (0x0F + 0xF5 mod 256).
4. **Contention:** A and B both hold write requests continuously.
   - With REGFILE_ARB_RR_EN: grants alternate A, B, A, B.
   - Without it: A, A, A, and ack_b never asserts.
5. **Reset mid-add:** rst low during A's READ → no rf_wen and no ack that cycle or the next, busy = 0; after release A is re-served and acked.
6. **Back-to-back adds to one register:** A then B each add data 1 to addr 2 → entry 2 goes 2 → 3 → 4, with no lost update.
